// File: rtl/dmem_arbiter.sv
// Round-robin two-port front end for the shared data memory: one request in flight,
// one-cycle memory access from registered strobes, one-cycle response pulse to the owner.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_valid,
  input  logic                  p1_valid,
  output logic                  p0_ready,
  output logic                  p1_ready,
  input  logic                  p0_we,
  input  logic                  p1_we,
  input  logic [DM_ADDRESS-1:0] p0_addr,
  input  logic [DM_ADDRESS-1:0] p1_addr,
  input  logic [DATA_W-1:0]     p0_wdata,
  input  logic [DATA_W-1:0]     p1_wdata,
  input  logic [2:0]            p0_funct3,
  input  logic [2:0]            p1_funct3,
  output logic                  p0_resp_valid,
  output logic                  p1_resp_valid,
  output logic                  p0_resp_err,
  output logic                  p1_resp_err,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  mem_MemRead,
  output logic                  mem_MemWrite,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_Funct3,
  input  logic [DATA_W-1:0]     mem_rd
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic [2:0]            funct3;
    logic                  owner;
    logic                  err;
  } req_t;

  state_t                state, nstate;
  req_t                  req, in_req;
  logic                  ptr, gnt_any, gnt_p1;
  logic [DATA_W-1:0]     rdata_q;
  logic                  rd_q, wr_q;
  logic [DM_ADDRESS-1:0] a_q;
  logic [DATA_W-1:0]     wd_q;
  logic [2:0]            f3_q;

  function automatic logic legal(input logic we, input logic [1:0] lsb, input logic [2:0] f3);
    case (f3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~lsb[0];
      3'b010:  legal = (lsb == 2'b00);
      3'b100:  legal = ~we;
      default: legal = 1'b0;
    endcase
  endfunction

  assign gnt_any = p0_valid | p1_valid;
  assign gnt_p1  = p1_valid & (~p0_valid | ptr);

  always_comb begin
    in_req.we     = gnt_p1 ? p1_we     : p0_we;
    in_req.addr   = gnt_p1 ? p1_addr   : p0_addr;
    in_req.wdata  = gnt_p1 ? p1_wdata  : p0_wdata;
    in_req.funct3 = gnt_p1 ? p1_funct3 : p0_funct3;
    in_req.owner  = gnt_p1;
    in_req.err    = ~legal(in_req.we, in_req.addr[1:0], in_req.funct3);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nstate;

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (gnt_any) nstate = in_req.err ? RESP : ACCESS;
      ACCESS:  nstate = RESP;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Strobes and memory payload are flops so they stay glitch-free across the falling-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req     <= '0;
      ptr     <= 1'b0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      a_q     <= '0;
      wd_q    <= '0;
      f3_q    <= '0;
    end else begin
      if (state == IDLE && gnt_any) begin
        req     <= in_req;
        ptr     <= ~gnt_p1;
        rdata_q <= '0;
        if (!in_req.err) begin
          rd_q <= ~in_req.we;
          wr_q <= in_req.we;
          a_q  <= in_req.addr;
          wd_q <= in_req.wdata;
          f3_q <= in_req.funct3;
        end
      end
      if (state == ACCESS) begin
        rd_q    <= 1'b0;
        wr_q    <= 1'b0;
        rdata_q <= req.we ? '0 : mem_rd;
      end
    end
  end

  // Ready is gated by rst_n so it reads 0 while reset is held even with valids high.
  always_comb begin
    p0_ready      = rst_n & (state == IDLE) & gnt_any & ~gnt_p1;
    p1_ready      = rst_n & (state == IDLE) & gnt_p1;
    p0_resp_valid = (state == RESP) & ~req.owner;
    p1_resp_valid = (state == RESP) &  req.owner;
    p0_resp_err   = p0_resp_valid & req.err;
    p1_resp_err   = p1_resp_valid & req.err;
    resp_rdata    = (state == RESP) ? rdata_q : '0;
  end

  assign mem_MemRead  = rd_q;
  assign mem_MemWrite = wr_q;
  assign mem_a        = a_q;
  assign mem_wd       = wd_q;
  assign mem_Funct3   = f3_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Random + directed bench for dmem_arbiter: a cycle-timed transaction model predicts grants,
// strobes and responses; a byte-array memory stands in for datamemory.
module tb_dmem_arbiter;
  localparam int AW = 9, DW = 32;

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          v[2], we[2];
  logic [AW-1:0] ad[2];
  logic [DW-1:0] wd[2];
  logic [2:0]    f3[2];

  logic          p0_ready, p1_ready, p0_resp_valid, p1_resp_valid, p0_resp_err, p1_resp_err;
  logic [DW-1:0] resp_rdata, mem_wd, mem_rd;
  logic          mem_MemRead, mem_MemWrite;
  logic [AW-1:0] mem_a;
  logic [2:0]    mem_Funct3;

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(v[0]), .p1_valid(v[1]), .p0_ready(p0_ready), .p1_ready(p1_ready),
    .p0_we(we[0]), .p1_we(we[1]), .p0_addr(ad[0]), .p1_addr(ad[1]),
    .p0_wdata(wd[0]), .p1_wdata(wd[1]), .p0_funct3(f3[0]), .p1_funct3(f3[1]),
    .p0_resp_valid(p0_resp_valid), .p1_resp_valid(p1_resp_valid),
    .p0_resp_err(p0_resp_err), .p1_resp_err(p1_resp_err), .resp_rdata(resp_rdata),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_Funct3(mem_Funct3), .mem_rd(mem_rd)
  );

  function automatic logic [31:0] ld(logic [31:0] w, logic [2:0] f);
    case (f)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd4:    return {24'b0, w[7:0]};
      default: return w;
    endcase
  endfunction

  function automatic int nbytes(logic [2:0] f);
    return (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit legal(bit w, logic [AW-1:0] a, logic [2:0] f);
    if (f == 3'd4) return !w;
    if (f > 3'd2) return 0;
    return (int'(a) % (1 << f)) == 0;
  endfunction

  // Stand-in data memory: combinational read, falling-edge write.
  logic [7:0] mem[512], ref_mem[512];
  assign mem_rd = ld({mem[9'(mem_a + 9'd3)], mem[9'(mem_a + 9'd2)], mem[9'(mem_a + 9'd1)], mem[mem_a]},
                     mem_Funct3);
  always @(negedge clk)
    if (mem_MemWrite)
      for (int i = 0; i < nbytes(mem_Funct3); i++) mem[9'(int'(mem_a) + i)] <= mem_wd[8*i +: 8];

  int n_chk = 0, n_fail = 0;
  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Transaction model: timing expressed as absolute cycle numbers.
  int cyc = 0, free_at = 0, st_cyc = -1, rs_cyc = -1;
  bit ptr = 0, st_we, rs_port, rs_err;
  logic [AW-1:0] st_a;
  logic [DW-1:0] st_wd, rs_data;
  logic [2:0] st_f3;
  bit keep[2] = '{0, 0};
  int gp[$], gc[$];

  task automatic tick();
    int g;
    logic [31:0] w;
    #5;
    g = -1;
    if (cyc >= free_at) begin
      if (v[0] && v[1]) g = int'(ptr);
      else if (v[0])    g = 0;
      else if (v[1])    g = 1;
    end
    chk("p0_ready", 32'(p0_ready), 32'(g == 0));
    chk("p1_ready", 32'(p1_ready), 32'(g == 1));
    chk("mem_read", 32'(mem_MemRead), 32'(st_cyc == cyc && !st_we));
    chk("mem_write", 32'(mem_MemWrite), 32'(st_cyc == cyc && st_we));
    if (st_cyc == cyc) begin
      chk("mem_a", 32'(mem_a), 32'(st_a));
      chk("mem_f3", 32'(mem_Funct3), 32'(st_f3));
      if (st_we) chk("mem_wd", mem_wd, st_wd);
    end
    chk("p0_resp_valid", 32'(p0_resp_valid), 32'(rs_cyc == cyc && !rs_port));
    chk("p1_resp_valid", 32'(p1_resp_valid), 32'(rs_cyc == cyc && rs_port));
    if (rs_cyc == cyc) begin
      chk("resp_err", 32'(rs_port ? p1_resp_err : p0_resp_err), 32'(rs_err));
      chk("resp_rdata", resp_rdata, rs_data);
    end
    if (p0_ready) begin gp.push_back(0); gc.push_back(cyc); end
    if (p1_ready) begin gp.push_back(1); gc.push_back(cyc); end
    if (g >= 0) begin
      if (legal(we[g], ad[g], f3[g])) begin
        st_cyc = cyc + 1; st_we = we[g]; st_a = ad[g]; st_wd = wd[g]; st_f3 = f3[g];
        if (we[g]) begin
          for (int i = 0; i < nbytes(f3[g]); i++) ref_mem[9'(int'(ad[g]) + i)] = wd[g][8*i +: 8];
          rs_data = '0;
        end else begin
          w = {ref_mem[9'(ad[g] + 9'd3)], ref_mem[9'(ad[g] + 9'd2)], ref_mem[9'(ad[g] + 9'd1)], ref_mem[ad[g]]};
          rs_data = ld(w, f3[g]);
        end
        rs_err = 0; rs_cyc = cyc + 2; free_at = cyc + 3;
      end else begin
        rs_err = 1; rs_data = '0; rs_cyc = cyc + 1; free_at = cyc + 2;
      end
      rs_port = g[0];
      ptr = !g[0];
    end
    @(posedge clk); #1;
    cyc++;
    if (g >= 0 && !keep[g]) v[g] = 1'b0;
  endtask

  task automatic issue(int p, bit w, logic [AW-1:0] a, logic [DW-1:0] d, logic [2:0] f);
    v[p] = 1'b1; we[p] = w; ad[p] = a; wd[p] = d; f3[p] = f;
  endtask

  task automatic drain();
    int k = 0;
    while ((v[0] || v[1] || cyc < free_at) && k < 60) begin tick(); k++; end
    n_chk++;
    if (k >= 60) begin n_fail++; $display("FAIL drain_timeout: got %0d cycles expected <60", k); end
  endtask

  // Asserts reset with both ports requesting; every output must read 0 while held.
  task automatic do_reset();
    issue(0, 0, 9'h010, '0, 3'd2);
    issue(1, 0, 9'h020, '0, 3'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'({p0_ready, p1_ready}), 0);
    chk("rst_resp", 32'({p0_resp_valid, p1_resp_valid, p0_resp_err, p1_resp_err}), 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_strobes", 32'({mem_MemRead, mem_MemWrite}), 0);
    chk("rst_mem_a", 32'(mem_a), 0);
    chk("rst_mem_wd", mem_wd, 0);
    chk("rst_mem_f3", 32'(mem_Funct3), 0);
    @(posedge clk); #1;
    cyc++;
    v[0] = 1'b0; v[1] = 1'b0;
    rst_n = 1'b1;
    ptr = 0; free_at = cyc; st_cyc = -1; rs_cyc = -1;
  endtask

  initial begin
    logic [2:0] ftab[8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd4};
    for (int i = 0; i < 512; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
    for (int p = 0; p < 2; p++) begin v[p] = 0; we[p] = 0; ad[p] = '0; wd[p] = '0; f3[p] = '0; end
    #1;
    do_reset();

    // store then load back a word on port 0
    issue(0, 1, 9'h010, 32'hDEADBEEF, 3'd2); drain();
    issue(0, 0, 9'h010, '0, 3'd2);           drain();

    // both ports holding valid right after reset: grants p0,p1,p0,p1 three cycles apart
    do_reset();
    gp.delete(); gc.delete();
    keep[0] = 1; keep[1] = 1;
    issue(0, 0, 9'h010, '0, 3'd2);
    issue(1, 0, 9'h024, '0, 3'd1);
    repeat (12) tick();
    keep[0] = 0; keep[1] = 0;
    v[0] = 0; v[1] = 0;
    drain();
    chk("gnt_count", 32'(gp.size() >= 4), 1);
    if (gp.size() >= 4) begin
      chk("gnt_order", {8'(gp[0]), 8'(gp[1]), 8'(gp[2]), 8'(gp[3])}, 32'h00010001);
      chk("gnt_gap", 32'(gc[1] - gc[0]), 3);
    end

    // illegal accesses: misaligned LH on p1, store with funct3 100 on p0
    issue(1, 0, 9'h003, '0, 3'd1);            drain();
    issue(0, 1, 9'h040, 32'h12345678, 3'd4);  drain();

    // pointer at 1 but only p0 valid, then both valid: p1 must win
    issue(0, 0, 9'h100, '0, 3'd0); drain();
    issue(0, 0, 9'h101, '0, 3'd4); drain();
    issue(0, 0, 9'h102, '0, 3'd0);
    issue(1, 1, 9'h104, 32'hCAFEF00D, 3'd2);
    drain();

    // reset asserted during the ACCESS cycle of a p0 load
    issue(0, 0, 9'h010, '0, 3'd2);
    tick();
    #2;
    do_reset();
    issue(0, 0, 9'h014, '0, 3'd2);
    issue(1, 0, 9'h018, '0, 3'd2);
    drain();

    // random traffic
    repeat (3000) begin
      for (int p = 0; p < 2; p++)
        if (!v[p] && $urandom_range(2) == 0) begin
          logic [AW-1:0] a;
          logic [2:0] f;
          a = AW'($urandom);
          if ($urandom_range(1) == 0) a[1:0] = 2'b00;
          f = ($urandom_range(9) < 8) ? ftab[$urandom_range(7)] : 3'($urandom);
          issue(p, 1'($urandom), a, $urandom, f);
        end
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
